uart_byte_fifo: RTL and testbench
=================================

// Module: uart_byte_fifo
// PURPOSE
//   Synchronous byte FIFO sitting between uart_rx (upstream) and uart_tx (downstream)
//   in the loopback/echo path. Absorbs bursts while uart_tx is busy shifting a frame.
//   Flags and counts bytes dropped when a non-stallable producer (uart_rx) pushes into a full FIFO.
// PARAMETERS
//   DEPTH      16   entries; power of two, >= 2
//   DATA_WIDTH 8    bits per entry
// PORTS
//   clock          in   1                    system clock
//   reset          in   1                    synchronous, active-high
//   in_valid       in   1                    producer has a byte on in_data
//   in_ready       out  1                    FIFO accepts; == !full
//   in_data        in   DATA_WIDTH           byte from uart_rx
//   out_valid      out  1                    out_data holds head entry; == !empty
//   out_ready      in   1                    consumer (uart_tx) takes head this cycle
//   out_data       out  DATA_WIDTH           head entry, first-word-fall-through
//   level          out  $clog2(DEPTH)+1      entries currently stored, 0..DEPTH
//   overflow       out  1                    sticky: a byte was dropped since last clear
//   drop_count     out  8                    bytes dropped, saturates at 255
//   clear_overflow in   1                    clears overflow and drop_count
// BEHAVIOUR
//   - Reset (sync, active-high): wr_ptr=rd_ptr=0, level=0, in_ready=1, out_valid=0,
//     out_data=0, overflow=0, drop_count=0. Reset mid-operation discards all contents.
//   - Storage: DEPTH x DATA_WIDTH array; pointers $clog2(DEPTH)+1 bits (extra wrap bit);
//     empty when ptrs equal, full when index equal and wrap bits differ. Wrap is natural.
//   - push = in_valid & in_ready; pop = out_valid & out_ready.
//   - Push writes mem[wr_ptr], wr_ptr++. Pop rd_ptr++. Both in same cycle: level unchanged.
//   - in_ready = !full, registered-equivalent (derived from pointers only, not from out_ready);
//     when full, a simultaneous pop does NOT allow a push in the same cycle.
//   - out_valid/out_data derived from registered pointers + memory read: a byte pushed into an
//     empty FIFO at edge N is visible on out_valid/out_data after edge N (1-cycle latency).
//   - out_data undefined-free: holds last head value (or 0 after reset) while out_valid=0.
//   - Ordering strictly FIFO; no byte duplicated or reordered across pointer wrap.
//   - Drop: in_valid & full -> byte discarded, overflow<=1, drop_count<=min(drop_count+1,255).
//   - clear_overflow: overflow<=0, drop_count<=0 next edge; if a drop occurs in the same cycle,
//     the drop wins: overflow<=1, drop_count<=1.
//   - level = wr_ptr - rd_ptr (modulo pointer width); level==DEPTH iff full.
//   - No combinational path from out_ready to in_ready, or from in_valid to out_valid.
// TESTING
//   1. Reset, push 0x41 one cycle, out_ready=0 -> next cycle out_valid=1, out_data=0x41, level=1.
//   2. Push 0x00..0x0F (DEPTH=16), no pops -> level=16, in_ready=0; pop all -> 0x00..0x0F in order, out_valid=0 after.
//   3. Full FIFO, push 0xAA with out_ready=1 same cycle -> 0xAA dropped, overflow=1, drop_count=1, level=15.
//   4. Continuous push+pop for 40 cycles (count 0..39) -> output sequence 0..39, level constant, pointers wrap twice.
//   5. Force 300 drops -> drop_count=255 saturated; clear_overflow pulse -> overflow=0, drop_count=0; clear+drop same cycle -> 1/1.
//   6. Reset asserted with level=7 -> next cycle level=0, out_valid=0, in_ready=1, flags cleared.

Source files
------------

// File: rtl/uart_byte_fifo.sv
// Byte FIFO between uart_rx and uart_tx: first-word-fall-through head, registered flags,
// sticky overflow and saturating drop counter for a producer that cannot be stalled.
module uart_byte_fifo #(
  parameter int unsigned DEPTH      = 16,
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [DATA_WIDTH-1:0]         in_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [DATA_WIDTH-1:0]         out_data,
  output logic [$clog2(DEPTH):0]        level,
  output logic                          overflow,
  output logic [7:0]                    drop_count,
  input  logic                          clear_overflow
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;
  localparam int unsigned CW = 8;
  localparam logic [CW-1:0] CNT_MAX = '1;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]         level_q, level_d;
  logic                  in_ready_q, in_ready_d;
  logic                  out_valid_q, out_valid_d;
  logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
  logic                  overflow_q, overflow_d;
  logic [CW-1:0]         drop_count_q, drop_count_d;

  logic                  push, pop, drop;
  logic                  empty_d, full_d;
  logic [AW-1:0]         wr_idx, rd_idx_d;

  // Pointer, flag and head-register next state; all flags come from registered pointers only
  always_comb begin
    push     = in_valid & in_ready_q;
    pop      = out_valid_q & out_ready;
    drop     = in_valid & ~in_ready_q;

    wr_ptr_d = wr_ptr_q + PW'(push);
    rd_ptr_d = rd_ptr_q + PW'(pop);
    wr_idx   = wr_ptr_q[AW-1:0];
    rd_idx_d = rd_ptr_d[AW-1:0];

    empty_d  = (wr_ptr_d == rd_ptr_d);
    full_d   = (wr_ptr_d[AW-1:0] == rd_idx_d) && (wr_ptr_d[AW] != rd_ptr_d[AW]);

    level_d     = wr_ptr_d - rd_ptr_d;
    in_ready_d  = ~full_d;
    out_valid_d = ~empty_d;

    // New head may be the byte being written this very edge
    out_data_d = out_data_q;
    if (!empty_d) begin
      if (push && (wr_idx == rd_idx_d)) begin
        out_data_d = in_data;
      end else begin
        out_data_d = mem_q[rd_idx_d];
      end
    end

    overflow_d   = overflow_q;
    drop_count_d = drop_count_q;
    if (drop) begin
      overflow_d   = 1'b1;
      if (clear_overflow) begin
        drop_count_d = CW'(1);
      end else if (drop_count_q != CNT_MAX) begin
        drop_count_d = drop_count_q + CW'(1);
      end
    end else if (clear_overflow) begin
      overflow_d   = 1'b0;
      drop_count_d = '0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      level_q      <= '0;
      in_ready_q   <= 1'b1;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      overflow_q   <= 1'b0;
      drop_count_q <= '0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      level_q      <= level_d;
      in_ready_q   <= in_ready_d;
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      overflow_q   <= overflow_d;
      drop_count_q <= drop_count_d;
    end
  end

  // Storage array carries no reset; validity is tracked by the pointers
  always_ff @(posedge clock) begin
    if (push) begin
      mem_q[wr_idx] <= in_data;
    end
  end

  assign in_ready   = in_ready_q;
  assign out_valid  = out_valid_q;
  assign out_data   = out_data_q;
  assign level      = level_q;
  assign overflow   = overflow_q;
  assign drop_count = drop_count_q;

endmodule

// File: tb/tb_uart_byte_fifo.sv
// Directed self-checking bench for uart_byte_fifo (DEPTH=16, 8-bit data).
module tb_uart_byte_fifo;

  logic       clock;
  logic       reset;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic [4:0] level;
  logic       overflow;
  logic [7:0] drop_count;
  logic       clear_overflow;

  int n_total = 0;
  int n_pass  = 0;

  uart_byte_fifo #(.DEPTH(16), .DATA_WIDTH(8)) dut (
    .clock          (clock),
    .reset          (reset),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_data        (in_data),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_data       (out_data),
    .level          (level),
    .overflow       (overflow),
    .drop_count     (drop_count),
    .clear_overflow (clear_overflow)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete, observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_data = 8'h00; out_ready = 1'b0; clear_overflow = 1'b0;
    tick(); tick();
    reset = 1'b0;
    chk("rst_level", 32'(level), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'h00);
    chk("rst_overflow", 32'(overflow), 32'd0);
    chk("rst_drop_count", 32'(drop_count), 32'd0);

    // Single byte, 1-cycle latency
    in_valid = 1'b1; in_data = 8'h41;
    tick();
    in_valid = 1'b0;
    chk("t1_out_valid", 32'(out_valid), 32'd1);
    chk("t1_out_data", 32'(out_data), 32'h41);
    chk("t1_level", 32'(level), 32'd1);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("t1_empty", 32'(out_valid), 32'd0);
    chk("t1_level0", 32'(level), 32'd0);
    chk("t1_hold_data", 32'(out_data), 32'h41);

    // Fill to full
    for (int i = 0; i < 16; i++) begin
      in_valid = 1'b1; in_data = 8'(i);
      tick();
    end
    in_valid = 1'b0;
    chk("t2_level_full", 32'(level), 32'd16);
    chk("t2_in_ready", 32'(in_ready), 32'd0);
    chk("t2_head", 32'(out_data), 32'h00);

    // Push while full with simultaneous pop: byte is dropped
    in_valid = 1'b1; in_data = 8'hAA; out_ready = 1'b1;
    tick();
    in_valid = 1'b0; out_ready = 1'b0;
    chk("t3_overflow", 32'(overflow), 32'd1);
    chk("t3_drop_count", 32'(drop_count), 32'd1);
    chk("t3_level", 32'(level), 32'd15);
    chk("t3_in_ready", 32'(in_ready), 32'd1);

    // Drain remaining 0x01..0x0F in order
    out_ready = 1'b1;
    for (int i = 1; i < 16; i++) begin
      chk("t2_drain_valid", 32'(out_valid), 32'd1);
      chk("t2_drain_data", 32'(out_data), 32'(i));
      tick();
    end
    out_ready = 1'b0;
    chk("t2_drained_valid", 32'(out_valid), 32'd0);
    chk("t2_drained_level", 32'(level), 32'd0);

    clear_overflow = 1'b1;
    tick();
    clear_overflow = 1'b0;
    chk("clr_overflow", 32'(overflow), 32'd0);
    chk("clr_drop_count", 32'(drop_count), 32'd0);

    // Streaming push+pop across pointer wrap
    in_valid = 1'b1; in_data = 8'd0;
    tick();
    for (int i = 1; i <= 40; i++) begin
      in_valid = (i < 40); in_data = 8'(i); out_ready = 1'b1;
      chk("t4_level", 32'(level), 32'd1);
      chk("t4_data", 32'(out_data), 32'(i - 1));
      tick();
    end
    in_valid = 1'b0; out_ready = 1'b0;
    chk("t4_end_level", 32'(level), 32'd0);
    chk("t4_end_valid", 32'(out_valid), 32'd0);

    // Fill then 300 drops: counter saturates
    for (int i = 0; i < 16; i++) begin
      in_valid = 1'b1; in_data = 8'(8'h10 + i);
      tick();
    end
    chk("t5_level_full", 32'(level), 32'd16);
    for (int i = 0; i < 300; i++) tick();
    in_valid = 1'b0;
    chk("t5_overflow", 32'(overflow), 32'd1);
    chk("t5_drop_sat", 32'(drop_count), 32'd255);
    chk("t5_level", 32'(level), 32'd16);
    chk("t5_head", 32'(out_data), 32'h10);
    clear_overflow = 1'b1;
    tick();
    chk("t5_clr_overflow", 32'(overflow), 32'd0);
    chk("t5_clr_count", 32'(drop_count), 32'd0);
    in_valid = 1'b1; in_data = 8'hEE;
    tick();
    in_valid = 1'b0; clear_overflow = 1'b0;
    chk("t5_clrdrop_overflow", 32'(overflow), 32'd1);
    chk("t5_clrdrop_count", 32'(drop_count), 32'd1);

    // Pop 9 leaving 7, then reset discards everything
    out_ready = 1'b1;
    for (int i = 0; i < 9; i++) tick();
    out_ready = 1'b0;
    chk("t6_level7", 32'(level), 32'd7);
    chk("t6_head", 32'(out_data), 32'h19);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("t6_level", 32'(level), 32'd0);
    chk("t6_out_valid", 32'(out_valid), 32'd0);
    chk("t6_in_ready", 32'(in_ready), 32'd1);
    chk("t6_overflow", 32'(overflow), 32'd0);
    chk("t6_drop_count", 32'(drop_count), 32'd0);
    chk("t6_out_data", 32'(out_data), 32'h00);
    in_valid = 1'b1; in_data = 8'h5A;
    tick();
    in_valid = 1'b0;
    chk("t6_post_data", 32'(out_data), 32'h5A);
    chk("t6_post_level", 32'(level), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
